// File: rtl/csa_accumulator.sv
// Multi-beat carry-save accumulator: per-beat 3:2 compression of LANES operands into a
// redundant (sum, carry) pair, resolved by one registered CPA and held behind valid/ready.
module csa_accumulator #(
  parameter int XLEN      = 49,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 64,
  parameter int ACCW      = XLEN + 8,
  parameter int SIGNED    = 0,
  localparam int BW       = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES*XLEN-1:0] ops_i,
  input  logic                  last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACCW-1:0]       result_o,
  output logic [BW-1:0]         beats_o,
  output logic                  ovf_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ACCW-1:0]     acc_s, acc_c;
  logic [ACCW-1:0]     nxt_s, nxt_c;
  logic [ACCW-1:0]     lane, cy;
  logic                accept;
  logic                release_frame;

  function automatic logic [ACCW-1:0] ext(input logic [XLEN-1:0] v);
    logic sx;
    sx = (SIGNED != 0) && v[XLEN-1];
    return {{(ACCW-XLEN){sx}}, v};
  endfunction

  function automatic logic [ACCW-1:0] maj3(input logic [ACCW-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] b);
    return (b == BW'(MAX_BEATS)) ? b : b + BW'(1);
  endfunction

  assign in_ready_o    = (state_q == IDLE) || (state_q == ACCUM);
  assign out_valid_o   = (state_q == DONE);
  assign accept        = in_valid_i && in_ready_o && !clear_i;
  assign release_frame = (state_q == DONE) && out_ready_i;

  // Compressor chain: each lane folds into the redundant pair; carries shift left, MSB dropped.
  always_comb begin
    nxt_s = acc_s;
    nxt_c = acc_c;
    lane  = '0;
    cy    = '0;
    for (int k = 0; k < LANES; k++) begin
      lane  = ext(ops_i[k*XLEN +: XLEN]);
      cy    = maj3(nxt_s, nxt_c, lane) << 1;
      nxt_s = nxt_s ^ nxt_c ^ lane;
      nxt_c = cy;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: if (in_valid_i) state_d = last_i ? RESOLVE : ACCUM;
        RESOLVE:     state_d = DONE;
        DONE:        if (out_ready_i) state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_s    <= '0;
      acc_c    <= '0;
      result_o <= '0;
      beats_o  <= '0;
      ovf_o    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_i || release_frame) begin
        acc_s   <= '0;
        acc_c   <= '0;
        beats_o <= '0;
        ovf_o   <= 1'b0;
      end else if (accept) begin
        acc_s   <= nxt_s;
        acc_c   <= nxt_c;
        beats_o <= sat_inc(beats_o);
        if (beats_o == BW'(MAX_BEATS)) ovf_o <= 1'b1;
      end
      // Single carry-propagate add; carry-out past ACCW is discarded.
      if (state_q == RESOLVE && !clear_i) result_o <= acc_s + acc_c;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: unsigned and signed instances share one stimulus stream.
module tb_csa_accumulator;
  localparam int XLEN = 8, LANES = 4, MAXB = 64, ACCW = 16, BW = 7;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid, last, out_ready;
  logic [LANES*XLEN-1:0] ops;
  logic in_ready_u, in_ready_s, out_valid_u, out_valid_s, ovf_u, ovf_s;
  logic [ACCW-1:0] res_u, res_s;
  logic [BW-1:0] beats_u, beats_s;
  int total = 0, bad = 0, stalls = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.XLEN(XLEN), .LANES(LANES), .MAX_BEATS(MAXB), .ACCW(ACCW), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready_u),
    .ops_i(ops), .last_i(last), .out_valid_o(out_valid_u), .out_ready_i(out_ready),
    .result_o(res_u), .beats_o(beats_u), .ovf_o(ovf_u));

  csa_accumulator #(.XLEN(XLEN), .LANES(LANES), .MAX_BEATS(MAXB), .ACCW(ACCW), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .ops_i(ops), .last_i(last), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
    .result_o(res_s), .beats_o(beats_s), .ovf_o(ovf_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] v, input logic l);
    in_valid = 1'b1;
    ops      = v;
    last     = l;
    if (!in_ready_u) stalls++;
    tick();
    in_valid = 1'b0;
    last     = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [15:0] eu, input logic [15:0] es,
                          input logic [6:0] eb, input logic eo);
    chk({tag, "_valid"}, 32'(out_valid_u), 32'd1);
    chk({tag, "_res_u"}, 32'(res_u), 32'(eu));
    chk({tag, "_res_s"}, 32'(res_s), 32'(es));
    chk({tag, "_beats"}, 32'(beats_u), 32'(eb));
    chk({tag, "_ovf"}, 32'(ovf_u), 32'(eo));
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [15:0] su, ss;
    int n;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; last = 1'b0; out_ready = 1'b0; ops = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready_u), 32'd1);
    chk("rst_out_valid", 32'(out_valid_u), 32'd0);
    chk("rst_result", 32'(res_u), 32'd0);
    chk("rst_beats", 32'(beats_u), 32'd0);
    chk("rst_ovf", 32'(ovf_u), 32'd0);
    rst_n = 1'b1;
    tick();

    // single beat {1,2,3,4}
    beat({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    chk("t1_resolve_valid", 32'(out_valid_u), 32'd0);
    chk("t1_resolve_ready", 32'(in_ready_u), 32'd0);
    tick();
    chk_done("t1", 16'd10, 16'd10, 7'd1, 1'b0);
    consume();
    chk("t1_post_valid", 32'(out_valid_u), 32'd0);
    chk("t1_post_ready", 32'(in_ready_u), 32'd1);

    // 64 back-to-back beats of 0xFF lanes
    stalls = 0;
    for (int i = 0; i < 64; i++) beat(32'hFFFF_FFFF, i == 63);
    chk("t2_stalls", 32'(stalls), 32'd0);
    tick();
    chk_done("t2", 16'd65280, 16'hFF00, 7'd64, 1'b0);
    consume();

    // signed: {-1,-1,-1,-1} + {2,0,0,0}
    beat(32'hFFFF_FFFF, 1'b0);
    beat(32'h0000_0002, 1'b1);
    tick();
    chk_done("t3", 16'd1022, 16'hFFFE, 7'd2, 1'b0);
    consume();

    // backpressure in DONE with a pending beat
    beat({8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
    tick();
    in_valid = 1'b1; ops = {8'd0, 8'd0, 8'd0, 8'd7}; last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_ready", 32'(in_ready_u), 32'd0);
      chk("t4_hold_result", 32'(res_u), 32'd4);
      tick();
    end
    chk("t4_hold_valid", 32'(out_valid_u), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_hs_valid", 32'(out_valid_u), 32'd0);
    chk("t4_hs_ready", 32'(in_ready_u), 32'd1);
    tick();
    in_valid = 1'b0; last = 1'b0;
    tick();
    chk_done("t4", 16'd7, 16'd7, 7'd1, 1'b0);
    consume();

    // clear mid-frame, then {5,0,0,0}
    for (int i = 0; i < 3; i++) beat({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    clear = 1'b1; in_valid = 1'b1; ops = 32'h4040_4040; last = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0; last = 1'b0;
    chk("t5_clr_beats", 32'(beats_u), 32'd0);
    chk("t5_clr_valid", 32'(out_valid_u), 32'd0);
    chk("t5_clr_ready", 32'(in_ready_u), 32'd1);
    beat(32'h0000_0005, 1'b1);
    tick();
    chk_done("t5", 16'd5, 16'd5, 7'd1, 1'b0);
    consume();

    // async reset mid-frame
    beat({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    beat({8'd1, 8'd1, 8'd1, 8'd1}, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5r_beats", 32'(beats_u), 32'd0);
    chk("t5r_result", 32'(res_u), 32'd0);
    chk("t5r_valid", 32'(out_valid_u), 32'd0);
    chk("t5r_ready", 32'(in_ready_u), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    beat({8'd0, 8'd0, 8'd3, 8'd0}, 1'b1);
    tick();
    chk_done("t5r_next", 16'd3, 16'd3, 7'd1, 1'b0);
    consume();

    // 65 beats of ones: saturation and overflow flag
    for (int i = 0; i < 65; i++) beat({8'd1, 8'd1, 8'd1, 8'd1}, i == 64);
    tick();
    chk_done("t6", 16'd260, 16'd260, 7'd64, 1'b1);
    consume();
    beat(32'h0, 1'b1);
    tick();
    chk_done("t6_ovf_cleared", 16'd0, 16'd0, 7'd1, 1'b0);
    consume();

    // random frames vs a lane-summing model
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 10);
      su = '0; ss = '0;
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        for (int k = 0; k < LANES; k++) begin
          b  = v[k*8 +: 8];
          su = su + {8'd0, b};
          ss = ss + {{8{b[7]}}, b};
        end
        beat(v, i == n - 1);
      end
      tick();
      chk_done("rand", su, ss, 7'(n), 1'b0);
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
